uart_tx_scheduler: RTL and testbench

Sequences access to the UART transmitter's TX FIFO write port. It round-robin arbitrates packet-oriented byte streams from `N_REQ` requesters, and bounds each grant with a burst limit. It also schedules master configuration requests: it stops new traffic, drains the FIFO and the in-flight frame, then runs the `config_req_mst`/`req_done` handshake. It sits between the host-side byte sources and the transmitter block.

---
 rtl/uart_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler for the UART TX FIFO write port, with per-grant burst limiting
// and a drain-then-handshake sequence for transmitter configuration requests.
module uart_tx_scheduler #(
    parameter int N_REQ     = 2,
    parameter int MAX_BURST = 4,
    localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic                 cfg_start_i,
    output logic                 cfg_busy_o,
    input  logic                 tx_fifo_full_i,
    input  logic                 tx_fifo_empty_i,
    input  logic                 tx_done_i,
    input  logic                 req_done_i,
    output logic [7:0]           data_tx_o,
    output logic                 tx_fifo_write_o,
    output logic                 config_req_mst_o,
    output logic [GW-1:0]        grant_o,
    output logic                 grant_valid_o
);

    typedef enum logic [1:0] {
        ARB,
        XFER,
        CFG_DRAIN,
        CFG_REQ
    } state_t;

    localparam logic [GW-1:0] LAST_IDX   = GW'(N_REQ - 1);
    localparam logic [3:0]    BEAT_LIMIT = 4'(MAX_BURST - 1);

    state_t        state_q, state_d;
    logic [GW-1:0] owner_q, owner_d;
    logic [GW-1:0] last_owner_q, last_owner_d;
    logic [3:0]    beat_q, beat_d;
    logic          cfg_pending_q, cfg_pending_d;
    logic          in_flight_q, in_flight_d;
    logic          cfg_req_q, cfg_req_d;

    logic [GW-1:0] arb_pick;
    logic [GW-1:0] cand;
    logic          arb_found;
    logic          accept;

    // Search starts just after the previous owner, so it ends up with the lowest priority.
    always_comb begin
        arb_pick  = '0;
        cand      = '0;
        arb_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = GW'((int'(last_owner_q) + i) % N_REQ);
            if (!arb_found && req_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_pick  = cand;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        beat_d          = beat_q;
        cfg_pending_d   = cfg_pending_q;
        in_flight_d     = in_flight_q;
        cfg_req_d       = 1'b0;
        req_ready_o     = '0;
        tx_fifo_write_o = 1'b0;
        data_tx_o       = '0;
        accept          = 1'b0;

        if (cfg_start_i && !cfg_pending_q) begin
            cfg_pending_d = 1'b1;
        end

        case (state_q)
            ARB: begin
                // A start pulse arriving in ARB is honoured at once, ahead of any requester.
                if (cfg_pending_q || cfg_start_i) begin
                    state_d = CFG_DRAIN;
                end else if (arb_found) begin
                    state_d = XFER;
                    owner_d = arb_pick;
                end
            end
            XFER: begin
                req_ready_o[owner_q] = !tx_fifo_full_i;
                accept               = req_valid_i[owner_q] && !tx_fifo_full_i;
                tx_fifo_write_o      = accept;
                data_tx_o            = req_data_i[{owner_q, 3'b000} +: 8];
                if (accept) begin
                    if (req_last_i[owner_q] || beat_q == BEAT_LIMIT) begin
                        state_d      = ARB;
                        last_owner_d = owner_q;
                        beat_d       = '0;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            CFG_DRAIN: begin
                if (tx_fifo_empty_i && !in_flight_q) begin
                    state_d = CFG_REQ;
                end
            end
            CFG_REQ: begin
                cfg_req_d = !req_done_i;
                if (req_done_i) begin
                    state_d       = ARB;
                    cfg_pending_d = 1'b0;
                end
            end
            default: state_d = ARB;
        endcase

        // A write in the same cycle as end-of-frame keeps the transmitter marked busy.
        if (accept) begin
            in_flight_d = 1'b1;
        end else if (tx_done_i && tx_fifo_empty_i) begin
            in_flight_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ARB;
            owner_q       <= '0;
            last_owner_q  <= LAST_IDX;
            beat_q        <= '0;
            cfg_pending_q <= 1'b0;
            in_flight_q   <= 1'b0;
            cfg_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            beat_q        <= beat_d;
            cfg_pending_q <= cfg_pending_d;
            in_flight_q   <= in_flight_d;
            cfg_req_q     <= cfg_req_d;
        end
    end

    assign config_req_mst_o = cfg_req_q;
    assign cfg_busy_o       = cfg_pending_q;
    assign grant_o          = owner_q;
    assign grant_valid_o    = (state_q == XFER);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus a randomized phase,
// all compared cycle by cycle against a behavioural model of the scheduling rules.
module tb_uart_tx_scheduler;

    localparam int N_REQ     = 2;
    localparam int MAX_BURST = 4;

    localparam int P_ARB    = 0;
    localparam int P_XFER   = 1;
    localparam int P_DRAIN  = 2;
    localparam int P_CFGREQ = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        cfg_start, cfg_busy;
    logic        fifo_full, fifo_empty, tx_done, req_done;
    logic [7:0]  data_tx;
    logic        fifo_write, cfg_mst;
    logic [0:0]  grant;
    logic        grant_valid;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_last_i      (req_last),
        .req_ready_o     (req_ready),
        .cfg_start_i     (cfg_start),
        .cfg_busy_o      (cfg_busy),
        .tx_fifo_full_i  (fifo_full),
        .tx_fifo_empty_i (fifo_empty),
        .tx_done_i       (tx_done),
        .req_done_i      (req_done),
        .data_tx_o       (data_tx),
        .tx_fifo_write_o (fifo_write),
        .config_req_mst_o(cfg_mst),
        .grant_o         (grant),
        .grant_valid_o   (grant_valid)
    );

    // Per-requester byte sources kept as circular packet memories.
    logic [7:0] pkt_data [2][64];
    logic       pkt_last [2][64];
    int         head [2];
    int         tail [2];
    logic       hold [2];

    // Behavioural model of the scheduler.
    int   m_phase, m_owner, m_last, m_beats;
    logic m_pend, m_inflight, m_mst;

    logic [7:0] log_data [$];
    int         log_grant [$];
    int         log_cyc [$];

    int checks, errors, cyc;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic addByte(input int k, input logic [7:0] d, input logic l);
        pkt_data[k][tail[k] % 64] = d;
        pkt_last[k][tail[k] % 64] = l;
        tail[k]++;
    endtask

    task automatic addRandomPacket(input int k);
        int len;
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) addByte(k, 8'($urandom_range(0, 255)), (i == len - 1));
    endtask

    task automatic modelReset();
        m_phase = P_ARB; m_owner = 0; m_last = N_REQ - 1; m_beats = 0;
        m_pend = 1'b0; m_inflight = 1'b0; m_mst = 1'b0;
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < 2; k++) begin
            if (head[k] != tail[k] && !hold[k]) begin
                req_valid[k]       = 1'b1;
                req_data[8*k +: 8] = pkt_data[k][head[k] % 64];
                req_last[k]        = pkt_last[k][head[k] % 64];
            end else begin
                req_valid[k]       = 1'b0;
                req_data[8*k +: 8] = 8'($urandom_range(0, 255));
                req_last[k]        = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // Advances the model by one clock using the inputs that were present at the edge.
    task automatic modelAdvance(input logic accepted);
        logic n_pend, n_inflight, n_mst, found;
        int   k;
        n_pend = m_pend;
        if (cfg_start && !m_pend) n_pend = 1'b1;
        if (m_phase == P_CFGREQ && req_done) n_pend = 1'b0;
        n_mst = (m_phase == P_CFGREQ) && !req_done;
        n_inflight = accepted ? 1'b1 : ((tx_done && fifo_empty) ? 1'b0 : m_inflight);
        case (m_phase)
            P_ARB: begin
                if (m_pend || cfg_start) begin
                    m_phase = P_DRAIN;
                end else begin
                    found = 1'b0;
                    for (int i = 1; i <= N_REQ; i++) begin
                        k = (m_last + i) % N_REQ;
                        if (!found && req_valid[k]) begin
                            found = 1'b1; m_owner = k; m_phase = P_XFER; m_beats = 0;
                        end
                    end
                end
            end
            P_XFER: begin
                if (accepted) begin
                    m_beats++;
                    head[m_owner]++;
                    if (req_last[m_owner] || m_beats == MAX_BURST) begin
                        m_last = m_owner; m_phase = P_ARB;
                    end
                end
            end
            P_DRAIN:  if (fifo_empty && !m_inflight) m_phase = P_CFGREQ;
            default:  if (req_done) m_phase = P_ARB;
        endcase
        m_pend = n_pend; m_inflight = n_inflight; m_mst = n_mst;
    endtask

    task automatic runCycle();
        logic [1:0] exp_ready;
        logic       exp_write;
        logic [7:0] exp_data;
        applyStimulus();
        #1;
        exp_ready = '0; exp_write = 1'b0; exp_data = '0;
        if (m_phase == P_XFER) begin
            exp_ready[m_owner] = !fifo_full;
            exp_write          = req_valid[m_owner] && !fifo_full;
            exp_data           = req_data[8*m_owner +: 8];
        end
        checkOutput("ready", req_ready, exp_ready);
        checkOutput("write", fifo_write, exp_write);
        checkOutput("data", data_tx, exp_data);
        checkOutput("grant_valid", grant_valid, (m_phase == P_XFER));
        checkOutput("grant", grant, m_owner);
        checkOutput("cfg_mst", cfg_mst, m_mst);
        checkOutput("cfg_busy", cfg_busy, m_pend);
        if (fifo_write) begin
            log_data.push_back(data_tx);
            log_grant.push_back(int'(grant));
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        modelAdvance(exp_write);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clearLog();
        log_data.delete(); log_grant.delete(); log_cyc.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ready"}, req_ready, 0);
        checkOutput({tag, "_write"}, fifo_write, 0);
        checkOutput({tag, "_data"}, data_tx, 0);
        checkOutput({tag, "_mst"}, cfg_mst, 0);
        checkOutput({tag, "_busy"}, cfg_busy, 0);
        checkOutput({tag, "_grant"}, grant, 0);
        checkOutput({tag, "_gvalid"}, grant_valid, 0);
    endtask

    // Asserts reset between clock edges and expects outputs to clear before any edge.
    task automatic asyncReset(input string tag);
        #3 rst_n = 1'b0;
        #1 checkAllZero(tag);
        for (int k = 0; k < 2; k++) head[k] = tail[k];
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic checkLog(input string tag, input logic [7:0] exp_d [], input int exp_g []);
        checkOutput({tag, "_count"}, log_data.size(), exp_d.size());
        if (log_data.size() == exp_d.size()) begin
            for (int i = 0; i < exp_d.size(); i++) begin
                checkOutput($sformatf("%s_byte%0d", tag, i), log_data[i], exp_d[i]);
                checkOutput($sformatf("%s_grant%0d", tag, i), log_grant[i], exp_g[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int         n;
        logic       seen;
        logic [7:0] ed [];
        int         eg [];

        checks = 0; errors = 0; cyc = 0;
        req_valid = '0; req_data = '0; req_last = '0;
        cfg_start = 0; fifo_full = 0; fifo_empty = 0; tx_done = 0; req_done = 0;
        for (int k = 0; k < 2; k++) begin head[k] = 0; tail[k] = 0; hold[k] = 0; end
        modelReset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("por");
        rst_n = 1'b1;

        // Round robin: two 2-byte packets, one idle ARB cycle between them.
        clearLog();
        addByte(0, 8'hA1, 0); addByte(0, 8'hA2, 1);
        addByte(1, 8'hB1, 0); addByte(1, 8'hB2, 1);
        repeat (8) runCycle();
        ed = '{8'hA1, 8'hA2, 8'hB1, 8'hB2}; eg = '{0, 0, 1, 1};
        checkLog("rr", ed, eg);
        if (log_cyc.size() == 4) checkOutput("rr_gap", log_cyc[2] - log_cyc[1], 2);

        // Burst cut: 6-byte packet is split after MAX_BURST bytes, requester 1 slips in.
        clearLog();
        for (int i = 0; i < 6; i++) addByte(0, 8'(8'h10 + i), (i == 5));
        addByte(1, 8'h20, 1);
        repeat (14) runCycle();
        ed = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h14, 8'h15}; eg = '{0, 0, 0, 0, 1, 0, 0};
        checkLog("burst", ed, eg);

        // Backpressure: FIFO full for three cycles mid-packet.
        clearLog();
        for (int i = 0; i < 4; i++) addByte(0, 8'(8'h30 + i), (i == 3));
        n = 0;
        while (log_data.size() < 2 && n < 10) begin runCycle(); n++; end
        checkOutput("bp_reach", log_data.size(), 2);
        fifo_full = 1;
        repeat (3) runCycle();
        checkOutput("bp_hold", log_data.size(), 2);
        fifo_full = 0;
        repeat (5) runCycle();
        ed = '{8'h30, 8'h31, 8'h32, 8'h33}; eg = '{0, 0, 0, 0};
        checkLog("bp", ed, eg);

        // Configuration during traffic: start pulse on the 2nd byte of a 3-byte packet.
        clearLog();
        addByte(0, 8'h40, 0); addByte(0, 8'h41, 0); addByte(0, 8'h42, 1);
        n = 0;
        while (log_data.size() < 1 && n < 6) begin runCycle(); n++; end
        checkOutput("cfg_first_byte", log_data.size(), 1);
        addByte(1, 8'h50, 1);
        cfg_start = 1; runCycle(); cfg_start = 0;
        runCycle();
        repeat (4) begin runCycle(); checkOutput("cfg_wait_empty", cfg_mst, 0); end
        fifo_empty = 1;
        repeat (3) begin runCycle(); checkOutput("cfg_wait_done", cfg_mst, 0); end
        tx_done = 1; runCycle(); tx_done = 0;
        n = 0;
        while (cfg_mst !== 1'b1 && n < 5) begin runCycle(); n++; end
        checkOutput("cfg_mst_rise", cfg_mst, 1);
        repeat (2) begin runCycle(); checkOutput("cfg_mst_hold", cfg_mst, 1); end
        req_done = 1; runCycle(); req_done = 0;
        checkOutput("cfg_mst_fall", cfg_mst, 0);
        checkOutput("cfg_busy_fall", cfg_busy, 0);
        n = 0;
        while (log_data.size() < 4 && n < 6) begin runCycle(); n++; end
        ed = '{8'h40, 8'h41, 8'h42, 8'h50}; eg = '{0, 0, 0, 1};
        checkLog("cfg", ed, eg);

        // Reset during XFER (requester 1 owns the grant).
        for (int i = 0; i < 4; i++) addByte(1, 8'(8'h60 + i), (i == 3));
        n = 0;
        while (grant_valid !== 1'b1 && n < 5) begin runCycle(); n++; end
        checkOutput("pre_rst_gvalid", grant_valid, 1);
        asyncReset("rst_xfer");

        // Idle configuration straight after reset, then reset during CFG_REQ.
        fifo_empty = 1; tx_done = 0; req_done = 0;
        cfg_start = 1; runCycle(); cfg_start = 0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            runCycle();
            if (cfg_mst === 1'b1) seen = 1'b1;
        end
        checkOutput("idle_cfg_latency", seen, 1);
        asyncReset("rst_cfg");

        // After release requester 0 must win first.
        clearLog();
        addByte(0, 8'h70, 1); addByte(1, 8'h71, 1);
        repeat (6) runCycle();
        ed = '{8'h70, 8'h71}; eg = '{0, 1};
        checkLog("post_rst", ed, eg);

        // Randomized traffic, backpressure, frame completions and config requests.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (tail[k] - head[k] < 8) addRandomPacket(k);
                hold[k] = ($urandom_range(0, 5) == 0);
            end
            fifo_full  = ($urandom_range(0, 3) == 0);
            fifo_empty = ($urandom_range(0, 1) == 0);
            tx_done    = ($urandom_range(0, 2) == 0);
            req_done   = ($urandom_range(0, 3) == 0);
            cfg_start  = ($urandom_range(0, 24) == 0);
            runCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
